ines_loader: RTL and testbench

Programming front-end for the NROM ROM store. It accepts a raw iNES image as a byte stream and validates the 16-byte header on the fly. It writes the whole file, header included, into the ROM store through its programming port (prog / prog_di / address), starting at address 0. It holds the CPU in reset until a complete, valid image has been written.

---
 rtl/ines_loader_if.sv | 20 ++
 rtl/ines_loader.sv | 134 +++++++++++++
 tb/tb_ines_loader.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ines_loader_if.sv
// Byte-stream input and ROM-store programming bus of the iNES loader.
// The loader sits on the slave side; the image source and the ROM store sit on the master side.
interface ines_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        prog;
  logic [15:0] prog_ab;
  logic [7:0]  prog_di;

  modport master (
    output in_valid, in_data,
    input  in_ready, prog, prog_ab, prog_di
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, prog, prog_ab, prog_di
  );
endinterface

// File: rtl/ines_loader.sv
// iNES image loader: validates the header while streaming the file into the NROM ROM store.
// The CPU is held in reset until a complete, valid image has been written.
module ines_loader #(
  parameter int IMAGE_LEN = 'h6010,
  parameter int HDR_LEN   = 16
) (
  input  logic          ppu_clk,
  input  logic          rst,
  input  logic          start,
  ines_loader_if.slave  bus,
  output logic          done,
  output logic          err,
  output logic          cpu_hold,
  output logic [15:0]   byte_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_BODY, S_FLUSH, S_DONE, S_ERROR
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(IMAGE_LEN - 1);
  localparam logic [15:0] HDR_LAST = 16'(HDR_LEN - 1);

  state_t      state_reg;
  logic        flush_last_reg;
  logic        prog_reg;
  logic [15:0] prog_ab_reg;
  logic [7:0]  prog_di_reg;
  logic        done_reg;
  logic        err_reg;
  logic        cpu_hold_reg;
  logic [15:0] byte_cnt_reg;
  logic [15:0] byte_cnt_next;
  logic        accept;

  function automatic logic hdr_ok(input logic [15:0] idx, input logic [7:0] d);
    logic ok;
    ok = 1'b1;
    case (idx)
      16'd0:        ok = (d == 8'h4E);
      16'd1:        ok = (d == 8'h45);
      16'd2:        ok = (d == 8'h53);
      16'd3:        ok = (d == 8'h1A);
      16'd4:        ok = (d == 8'h01);
      16'd5:        ok = (d == 8'h01);
      16'd6, 16'd7: ok = (d[7:4] == 4'h0);
      default:      ok = 1'b1;
    endcase
    return ok;
  endfunction

  assign bus.in_ready = (state_reg == S_HEADER) || (state_reg == S_BODY);
  assign accept       = bus.in_ready && bus.in_valid;
  // A 65536-byte image would wrap the 16-bit count on its last byte; hold at all-ones instead.
  assign byte_cnt_next = (byte_cnt_reg == 16'hFFFF) ? 16'hFFFF : byte_cnt_reg + 16'd1;

  always_ff @(posedge ppu_clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      flush_last_reg <= 1'b0;
      prog_reg       <= 1'b0;
      prog_ab_reg    <= 16'd0;
      prog_di_reg    <= 8'd0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      cpu_hold_reg   <= 1'b1;
      byte_cnt_reg   <= 16'd0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_reg    <= S_HEADER;
            prog_reg     <= 1'b0;
            prog_ab_reg  <= 16'd0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            cpu_hold_reg <= 1'b1;
            byte_cnt_reg <= 16'd0;
          end
        end
        S_HEADER: begin
          if (accept) begin
            if (!hdr_ok(byte_cnt_reg, bus.in_data)) begin
              state_reg <= S_ERROR;
              err_reg   <= 1'b1;
              prog_reg  <= 1'b0;
            end else begin
              prog_reg     <= 1'b1;
              prog_ab_reg  <= byte_cnt_reg;
              prog_di_reg  <= bus.in_data;
              byte_cnt_reg <= byte_cnt_next;
              if (byte_cnt_reg == HDR_LAST) begin
                state_reg <= S_BODY;
              end
            end
          end
        end
        S_BODY: begin
          if (accept) begin
            prog_reg     <= 1'b1;
            prog_ab_reg  <= byte_cnt_reg;
            prog_di_reg  <= bus.in_data;
            byte_cnt_reg <= byte_cnt_next;
            if (byte_cnt_reg == LAST_IDX) begin
              state_reg      <= S_FLUSH;
              flush_last_reg <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          // Keep prog up for two edges so the last byte is committed before the CPU is released.
          if (flush_last_reg) begin
            state_reg    <= S_DONE;
            prog_reg     <= 1'b0;
            done_reg     <= 1'b1;
            cpu_hold_reg <= 1'b0;
          end else begin
            flush_last_reg <= 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.prog    = prog_reg;
  assign bus.prog_ab = prog_ab_reg;
  assign bus.prog_di = prog_di_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign cpu_hold    = cpu_hold_reg;
  assign byte_cnt    = byte_cnt_reg;

endmodule

// File: tb/tb_ines_loader.sv
// Self-checking bench for ines_loader: header-rule vector table plus full-image load sequences
// against a behavioural model of the ROM store.
module tb_ines_loader;

  localparam int L = 'h6010;

  logic        ppu_clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        done, err, cpu_hold;
  logic [15:0] byte_cnt;

  ines_loader_if bus ();

  ines_loader dut (
    .ppu_clk  (ppu_clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold),
    .byte_cnt (byte_cnt)
  );

  always #5 ppu_clk = ~ppu_clk;

  int total = 0;
  int bad = 0;

  // ROM store model; an address counts as written when its tag equals the current load tag.
  logic [7:0] rom [0:65535];
  int         wr_tag [0:65535];
  int         cur_tag = 1;

  always @(posedge ppu_clk) begin
    if (bus.prog === 1'b1) begin
      rom[bus.prog_ab]    <= bus.prog_di;
      wr_tag[bus.prog_ab] <= cur_tag;
    end
  end

  typedef struct {
    int         idx;
    logic [7:0] val;
    bit         exp_err;
  } hdr_vec_t;

  hdr_vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ppu_clk);
    #1;
  endtask

  function automatic logic [7:0] img_byte(input int seed, input int i);
    case (i)
      0: return 8'h4E;
      1: return 8'h45;
      2: return 8'h53;
      3: return 8'h1A;
      4: return 8'h01;
      5: return 8'h01;
      6: return 8'h00;
      7: return 8'h00;
      default: return 8'(((i * 13) + seed) ^ (i >> 8));
    endcase
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_prog"}, bus.prog, 0);
    check({tag, "_prog_ab"}, bus.prog_ab, 0);
    check({tag, "_prog_di"}, bus.prog_di, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_cpu_hold"}, cpu_hold, 1);
    check({tag, "_byte_cnt"}, byte_cnt, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    check_reset(tag);
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Offers one byte and returns 1 ns after the edge that accepted it; in_valid is left high.
  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL push_timeout: in_ready %0b after %0d cycles, required 1", bus.in_ready, n);
    end
    tick();
  endtask

  function automatic int count_written(input int lo, input int hi);
    int c;
    c = 0;
    for (int a = lo; a <= hi; a++) begin
      if (wr_tag[a] == cur_tag) c++;
    end
    return c;
  endfunction

  task automatic load(input int seed, input int nbytes, input bit gaps, input int start_at);
    logic [15:0] ab;
    logic [7:0]  di;
    bit          ok;
    bit          stream_ok;
    int          g;
    stream_ok = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      if (i == start_at) start = 1'b1;
      push(img_byte(seed, i));
      start = 1'b0;
      if (bus.prog !== 1'b1 || bus.prog_ab !== 16'(i) || bus.prog_di !== img_byte(seed, i))
        stream_ok = 1'b0;
      if (gaps && i < nbytes - 1 && $urandom_range(0, 15) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        ab = bus.prog_ab;
        di = bus.prog_di;
        ok = 1'b1;
        g  = $urandom_range(1, 5);
        repeat (g) begin
          tick();
          if (bus.prog_ab !== ab || bus.prog_di !== di || bus.prog !== 1'b1 ||
              byte_cnt !== 16'(i + 1))
            ok = 1'b0;
        end
        check("gap_hold", ok, 1);
      end
    end
    bus.in_valid = 1'b0;
    check("stream_write_path", stream_ok, 1);
  endtask

  task automatic check_completion(input string tag);
    check({tag, "_flush_done"}, done, 0);
    check({tag, "_flush_prog"}, bus.prog, 1);
    check({tag, "_flush_in_ready"}, bus.in_ready, 0);
    tick();
    check({tag, "_n1_done"}, done, 0);
    check({tag, "_n1_cpu_hold"}, cpu_hold, 1);
    tick();
    check({tag, "_n2_done"}, done, 1);
    check({tag, "_n2_cpu_hold"}, cpu_hold, 0);
    check({tag, "_n2_prog"}, bus.prog, 0);
    check({tag, "_n2_err"}, err, 0);
    check({tag, "_byte_cnt"}, byte_cnt, 16'h6010);
  endtask

  task automatic check_rom(input string tag, input int seed);
    int miss;
    miss = 0;
    for (int a = 0; a < 65536; a++) begin
      if (a < L) begin
        if (wr_tag[a] != cur_tag || rom[a] !== img_byte(seed, a)) miss++;
      end else if (wr_tag[a] == cur_tag) begin
        miss++;
      end
    end
    check({tag, "_rom_mismatches"}, miss, 0);
  endtask

  initial begin
    vecs[0]  = '{0, 8'h4F, 1'b1};
    vecs[1]  = '{1, 8'h44, 1'b1};
    vecs[2]  = '{2, 8'h52, 1'b1};
    vecs[3]  = '{3, 8'h1B, 1'b1};
    vecs[4]  = '{4, 8'h02, 1'b1};
    vecs[5]  = '{4, 8'h00, 1'b1};
    vecs[6]  = '{5, 8'h02, 1'b1};
    vecs[7]  = '{6, 8'h10, 1'b1};
    vecs[8]  = '{7, 8'hF0, 1'b1};
    vecs[9]  = '{6, 8'h0F, 1'b0};
    vecs[10] = '{7, 8'h0F, 1'b0};
    vecs[11] = '{9, 8'hAA, 1'b0};

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    for (int a = 0; a < 65536; a++) wr_tag[a] = 0;

    #1 rst = 1'b0;
    #1 check_reset("por");
    tick();
    rst = 1'b1;
    tick();

    // Bytes offered in IDLE must not be consumed.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h4E;
    repeat (3) tick();
    check("idle_no_consume_cnt", byte_cnt, 0);
    check("idle_no_consume_prog", bus.prog, 0);
    bus.in_valid = 1'b0;
    $display("idle: offered bytes ignored, byte_cnt=%0d", byte_cnt);

    for (int v = 0; v < 12; v++) begin
      cur_tag++;
      pulse_start();
      check("hdr_start_in_ready", bus.in_ready, 1);
      for (int i = 0; i <= vecs[v].idx; i++)
        push((i == vecs[v].idx) ? vecs[v].val : img_byte(1, i));
      bus.in_valid = 1'b0;
      check("hdr_err", err, vecs[v].exp_err);
      check("hdr_in_ready", bus.in_ready, !vecs[v].exp_err);
      check("hdr_prog", bus.prog, !vecs[v].exp_err);
      check("hdr_cpu_hold", cpu_hold, 1);
      check("hdr_byte_cnt", byte_cnt, vecs[v].exp_err ? vecs[v].idx : vecs[v].idx + 1);
      tick();
      tick();
      check("hdr_written", count_written(0, 65535),
            vecs[v].exp_err ? vecs[v].idx : vecs[v].idx + 1);
      $display("hdr vec %0d: idx=%0d val=%02h err=%0b cnt=%0d", v, vecs[v].idx, vecs[v].val,
               err, byte_cnt);
      do_reset("vec_rst");
    end

    // Continuous full image with a start pulse landing in BODY.
    cur_tag++;
    pulse_start();
    load(5, L, 1'b0, 1000);
    check_completion("imgA");
    check_rom("imgA", 5);
    $display("image A: done=%0b cpu_hold=%0b byte_cnt=%0h", done, cpu_hold, byte_cnt);

    // start in DONE restarts the load.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_done", done, 0);
    check("restart_cpu_hold", cpu_hold, 1);
    check("restart_byte_cnt", byte_cnt, 0);
    check("restart_prog_ab", bus.prog_ab, 0);
    check("restart_in_ready", bus.in_ready, 1);
    $display("restart from DONE: done=%0b cpu_hold=%0b", done, cpu_hold);

    // Partial load interrupted by reset.
    cur_tag++;
    load(9, 5000, 1'b0, -1);
    check("partial_byte_cnt", byte_cnt, 5000);
    bus.in_valid = 1'b1;
    do_reset("mid_rst");
    bus.in_valid = 1'b0;
    $display("reset after 5000 bytes: byte_cnt=%0d cpu_hold=%0b", byte_cnt, cpu_hold);

    // Full reload with random idle gaps.
    cur_tag++;
    pulse_start();
    load(9, L, 1'b1, -1);
    check_completion("imgB");
    check_rom("imgB", 9);
    $display("image B (gaps): done=%0b cpu_hold=%0b byte_cnt=%0h", done, cpu_hold, byte_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
